mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 5-stage RV32I core; sits directly downstream of the MEM stage.
- Latches the MEM-cycle rd value and control, then aligns and extends the synchronous data-memory read data for loads (LB/LH/LW/LBU/LHU).
- Drives the register-file write port and WB forwarding data, and maintains a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_W, 5, register index width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  hold the WB register contents
flush  in  1  insert a bubble into WB
MEM_valid  in  1  MEM slot holds a real instruction
MEM_reg_write  in  1  instruction writes rd
MEM_load  in  1  instruction is a load
MEM_funct3  in  3  load size/sign
MEM_addr_lsb  in  2  DM byte address [1:0]
MEM_rd_addr  in  REG_ADDR_W  destination register
MEM_rd_data  in  DATA_WIDTH  ALU result or PC+4 chosen by MEM
DM_out  in  DATA_WIDTH  SRAM read data; valid in the cycle after the MEM-cycle address
WB_valid  out  1  WB slot holds a real instruction
WB_reg_write  out  1  register-file write enable
WB_rd_addr  out  REG_ADDR_W  register-file write index
WB_rd_data  out  DATA_WIDTH  register-file write data / forwarding value
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: asynchronous, active-high `rst`; clock `clk`. All pipeline registers, the hold register and `instret` clear to 0, so every output resets to 0.
- Capture: on posedge with `flush`=0 and `stall`=0, the WB registers load all MEM_* inputs. Latency is 1 cycle from MEM to WB.
- Flush: on posedge with `flush`=1, the slot becomes a bubble: valid=0, reg_write=0, load=0.
  - Flush has priority over `stall`.
  - A flush also clears the hold register's valid flag.
- Stall: on posedge with `stall`=1 and `flush`=0, the WB registers keep their values.
- DM hold: the SRAM output may change while WB is stalled, so the first stall cycle captures `DM_out` into `dm_hold` and sets `hold_vld`=1.
  - While `hold_vld`=1, the load path uses `dm_hold`; otherwise it uses `DM_out` directly.
  - `hold_vld` clears on the first posedge with `stall`=0.
- Load extend (combinational). Byte select = lsb; half select = lsb[1].
  - funct3 000 (LB): sign-extend the selected byte.
  - funct3 001 (LH): sign-extend the selected half.
  - funct3 010 (LW): full word.
  - funct3 100 (LBU): zero-extend the selected byte.
  - funct3 101 (LHU): zero-extend the selected half.
  - Any other funct3: full word.
  - Misaligned LH/LW: no trap is raised; the result is the computed select, with LH at lsb=3 treated as lsb[1]=1.
- WB_rd_data: the load-extended value when the WB `load` flag is 1, otherwise the registered `MEM_rd_data`.
- WB_reg_write = valid & reg_write & (rd_addr != 0). A write to x0 is never asserted.
- WB_valid: reflects the WB register's valid flag.
- instret: increments by 1 on each posedge where WB_valid=1 and `stall`=0; wraps modulo 2^CNT_W.
  - A bubble, or a slot held across N stall cycles, counts at most once.
- Reset mid-operation: the pipeline state is dropped immediately (asynchronous); no write is asserted during or after reset until a new valid capture.
- All outputs are derived from registers plus the load-extend logic; no combinational path from MEM_* inputs to outputs.

Decomposition:
- Shared package (`cpu_pkg`):
  - DATA_WIDTH and FUNCTION_3 widths.
  - funct3 load constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU.
  - REG_ADDR_W.
- Sub-module: `load_extend`, a combinational block taking (funct3, lsb, word) and returning the extended value. It is reusable by a future cache refill path.

Test Plan:
- LB: lsb=3, DM_out=0x80FF1234, rd=5 -> WB_rd_data=0xFFFFFF80, WB_reg_write=1, WB_rd_addr=5.
- LHU/LH: LHU with lsb=2, DM_out=0x80FF1234 -> 0x000080FF; LH with same inputs -> 0xFFFF80FF; LBU with lsb=1 -> 0x00000012.
- Stall: load captured with DM_out=0xDEADBEEF, then stall held 3 cycles while DM_out changes to 0x0 -> WB_rd_data stays 0xDEADBEEF (LW); instret increments once, after stall deasserts.
- Flush, x0: `flush` with `stall` both 1 on an ALU instruction -> WB_valid=0, WB_reg_write=0, instret unchanged. ALU writing rd=0 with data 0x1234 -> WB_valid=1, WB_reg_write=0, instret +1.
- Back-to-back retirement: 4 consecutive valid instructions -> instret counts 1..4. Preload the counter near 2^64-1 via a force -> wraps to 0.
- Reset mid-operation: assert `rst` asynchronously mid-cycle during a valid load in WB -> all outputs 0 immediately. After release, the first valid capture behaves normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: datapath widths and the load funct3 encodings
// used by the writeback stage and any other consumer of load data.
package cpu_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int FUNCTION_3_W = 3;
   localparam int REG_ADDR_W   = 5;
   localparam int CNT_W        = 64;

   localparam logic [FUNCTION_3_W-1:0] F3_LB  = 3'b000;
   localparam logic [FUNCTION_3_W-1:0] F3_LH  = 3'b001;
   localparam logic [FUNCTION_3_W-1:0] F3_LW  = 3'b010;
   localparam logic [FUNCTION_3_W-1:0] F3_LBU = 3'b100;
   localparam logic [FUNCTION_3_W-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB boundary bundle: MEM-cycle instruction fields, SRAM read data,
// pipeline control, and the writeback/forwarding results.
interface mem_wb_stage_if #(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter int CNT_W      = cpu_pkg::CNT_W
);
   logic                    stall;
   logic                    flush;
   logic                    MEM_valid;
   logic                    MEM_reg_write;
   logic                    MEM_load;
   logic [2:0]              MEM_funct3;
   logic [1:0]              MEM_addr_lsb;
   logic [REG_ADDR_W-1:0]   MEM_rd_addr;
   logic [DATA_WIDTH-1:0]   MEM_rd_data;
   logic [DATA_WIDTH-1:0]   DM_out;
   logic                    WB_valid;
   logic                    WB_reg_write;
   logic [REG_ADDR_W-1:0]   WB_rd_addr;
   logic [DATA_WIDTH-1:0]   WB_rd_data;
   logic [CNT_W-1:0]        instret;

   modport master (
      output stall, flush, MEM_valid, MEM_reg_write, MEM_load, MEM_funct3,
             MEM_addr_lsb, MEM_rd_addr, MEM_rd_data, DM_out,
      input  WB_valid, WB_reg_write, WB_rd_addr, WB_rd_data, instret
   );

   modport slave (
      input  stall, flush, MEM_valid, MEM_reg_write, MEM_load, MEM_funct3,
             MEM_addr_lsb, MEM_rd_addr, MEM_rd_data, DM_out,
      output WB_valid, WB_reg_write, WB_rd_addr, WB_rd_data, instret
   );

endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a 32-bit memory word and sign- or
// zero-extends it according to the load funct3. Purely combinational.
module load_extend
   import cpu_pkg::*;
(
   input  logic [FUNCTION_3_W-1:0] i_funct3,
   input  logic [1:0]              i_lsb,
   input  logic [DATA_WIDTH-1:0]   i_word,
   output logic [DATA_WIDTH-1:0]   o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Halfword select ignores lsb[0], so a misaligned LH at lsb=3 reads the upper half.
   always_comb begin
      w_byte = i_word[{i_lsb, 3'b000} +: 8];
      w_half = i_word[{i_lsb[1], 4'b0000} +: 16];
      o_data = i_word;
      case (i_funct3)
         F3_LB:   o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         F3_LH:   o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         F3_LW:   o_data = i_word;
         F3_LBU:  o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         F3_LHU:  o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: latches MEM results, extends
// load data from the synchronous SRAM, drives the RF write port and instret.
module mem_wb_stage #(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
   parameter int CNT_W      = cpu_pkg::CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   mem_wb_stage_if.slave bus
);

   localparam int F3_W = cpu_pkg::FUNCTION_3_W;

   logic                  r_valid;
   logic                  r_reg_write;
   logic                  r_load;
   logic [F3_W-1:0]       r_funct3;
   logic [1:0]            r_lsb;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [DATA_WIDTH-1:0] r_dm_hold;
   logic                  r_hold_vld;
   logic [CNT_W-1:0]      r_instret;

   logic [DATA_WIDTH-1:0] w_load_word;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic                  w_retire;

   // The WB slot retires on the edge that lets it move on; a held slot retires once.
   assign w_retire = r_valid & ~bus.stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_load      <= 1'b0;
         r_funct3    <= '0;
         r_lsb       <= '0;
         r_rd_addr   <= '0;
         r_rd_data   <= '0;
      end else if (bus.flush) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_load      <= 1'b0;
      end else if (!bus.stall) begin
         r_valid     <= bus.MEM_valid;
         r_reg_write <= bus.MEM_reg_write;
         r_load      <= bus.MEM_load;
         r_funct3    <= bus.MEM_funct3;
         r_lsb       <= bus.MEM_addr_lsb;
         r_rd_addr   <= bus.MEM_rd_addr;
         r_rd_data   <= bus.MEM_rd_data;
      end
   end

   // SRAM data is only valid in the first WB cycle; freeze it if WB stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dm_hold  <= '0;
         r_hold_vld <= 1'b0;
      end else if (bus.flush || !bus.stall) begin
         r_hold_vld <= 1'b0;
      end else if (!r_hold_vld) begin
         r_dm_hold  <= bus.DM_out;
         r_hold_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign w_load_word = r_hold_vld ? r_dm_hold : bus.DM_out;

   load_extend u_load_extend (
      .i_funct3 (r_funct3),
      .i_lsb    (r_lsb),
      .i_word   (w_load_word),
      .o_data   (w_load_data)
   );

   assign bus.WB_valid     = r_valid;
   assign bus.WB_reg_write = r_valid & r_reg_write & (r_rd_addr != '0);
   assign bus.WB_rd_addr   = r_rd_addr;
   assign bus.WB_rd_data   = r_load ? w_load_data : r_rd_data;
   assign bus.instret      = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed load/stall/flush/wrap/reset steps followed by
// random traffic, all checked against a slot-level model of writeback.
module tb_mem_wb_stage;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   mem_wb_stage_if bus_if ();

   mem_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the WB slot: the instruction sitting in WB and the memory word it sees.
   logic        m_valid, m_regw, m_load, m_first;
   logic [2:0]  m_f3;
   logic [1:0]  m_lsb;
   logic [4:0]  m_rd;
   logic [31:0] m_data, m_word;
   logic [63:0] m_cnt;

   function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] lsb,
                                           input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      logic        hsel;
      hsel = lsb[1];
      b = (w >> (8 * lsb)) & 32'hFF;
      h = (w >> (16 * hsel)) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 64'(bus_if.WB_valid), 64'(m_valid));
      chk({tag, ".we"}, 64'(bus_if.WB_reg_write), 64'(m_valid & m_regw & (m_rd != 5'd0)));
      chk({tag, ".instret"}, bus_if.instret, m_cnt);
      if (m_valid) begin
         chk({tag, ".rd"}, 64'(bus_if.WB_rd_addr), 64'(m_rd));
         chk({tag, ".data"}, 64'(bus_if.WB_rd_data),
             64'(m_load ? ref_ext(m_f3, m_lsb, m_word) : m_data));
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_regw = 1'b0; m_load = 1'b0; m_first = 1'b0;
      m_f3 = '0; m_lsb = '0; m_rd = '0; m_data = '0; m_word = '0; m_cnt = '0;
   endtask

   task automatic peek_dm(input logic [31:0] dm);
      bus_if.DM_out = dm;
      #1;
   endtask

   // One clock: drive MEM fields for the next capture and DM for the current WB slot.
   task automatic cycle(input string tag, input logic st, input logic fl,
                        input logic v, input logic rw, input logic ld,
                        input logic [2:0] f3, input logic [1:0] lsb,
                        input logic [4:0] rd, input logic [31:0] data,
                        input logic [31:0] dm);
      bus_if.stall         = st;
      bus_if.flush         = fl;
      bus_if.MEM_valid     = v;
      bus_if.MEM_reg_write = rw;
      bus_if.MEM_load      = ld;
      bus_if.MEM_funct3    = f3;
      bus_if.MEM_addr_lsb  = lsb;
      bus_if.MEM_rd_addr   = rd;
      bus_if.MEM_rd_data   = data;
      bus_if.DM_out        = dm;
      #1;
      if (m_first) m_word = dm;
      check_model(tag);
      @(posedge clk);
      if (m_valid && !st) m_cnt = m_cnt + 64'd1;
      if (fl) begin
         m_valid = 1'b0; m_regw = 1'b0; m_load = 1'b0; m_first = 1'b0;
      end else if (!st) begin
         m_valid = v; m_regw = rw; m_load = ld; m_f3 = f3; m_lsb = lsb;
         m_rd = rd; m_data = data; m_first = 1'b1;
      end else begin
         m_first = 1'b0;
      end
      @(negedge clk);
   endtask

   logic [63:0] snap;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();
      rst = 1'b1;
      bus_if.stall = 1'b0; bus_if.flush = 1'b0; bus_if.MEM_valid = 1'b0;
      bus_if.MEM_reg_write = 1'b0; bus_if.MEM_load = 1'b0; bus_if.MEM_funct3 = '0;
      bus_if.MEM_addr_lsb = '0; bus_if.MEM_rd_addr = '0; bus_if.MEM_rd_data = '0;
      bus_if.DM_out = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_model("reset");
      chk("reset.rd_addr", 64'(bus_if.WB_rd_addr), 64'd0);
      chk("reset.rd_data", 64'(bus_if.WB_rd_data), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back retirement from a freshly reset counter.
      for (int k = 1; k <= 4; k++) begin
         cycle($sformatf("b2b%0d", k), 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'(k), $urandom, $urandom);
         chk($sformatf("b2b%0d.count", k), bus_if.instret, 64'(k - 1));
      end
      cycle("b2b5", 0, 0, 1, 1, 1, 3'b000, 2'd3, 5'd5, $urandom, $urandom);
      chk("b2b5.count", bus_if.instret, 64'd4);

      // Load extension cases on the same memory word.
      peek_dm(32'h80FF_1234);
      chk("lb.data", 64'(bus_if.WB_rd_data), 64'h0000_0000_FFFF_FF80);
      chk("lb.we", 64'(bus_if.WB_reg_write), 64'd1);
      chk("lb.rd", 64'(bus_if.WB_rd_addr), 64'd5);
      cycle("lb", 0, 0, 1, 1, 1, 3'b101, 2'd2, 5'd7, $urandom, 32'h80FF_1234);
      peek_dm(32'h80FF_1234);
      chk("lhu.data", 64'(bus_if.WB_rd_data), 64'h0000_80FF);
      cycle("lhu", 0, 0, 1, 1, 1, 3'b001, 2'd2, 5'd8, $urandom, 32'h80FF_1234);
      peek_dm(32'h80FF_1234);
      chk("lh.data", 64'(bus_if.WB_rd_data), 64'hFFFF_80FF);
      cycle("lh", 0, 0, 1, 1, 1, 3'b100, 2'd1, 5'd9, $urandom, 32'h80FF_1234);
      peek_dm(32'h80FF_1234);
      chk("lbu.data", 64'(bus_if.WB_rd_data), 64'h0000_0012);
      cycle("lbu", 0, 0, 1, 1, 1, 3'b010, 2'd0, 5'd10, $urandom, 32'h80FF_1234);

      // LW held across three stall cycles while the SRAM output changes.
      snap = m_cnt;
      peek_dm(32'hDEAD_BEEF);
      chk("st0.data", 64'(bus_if.WB_rd_data), 64'hDEAD_BEEF);
      cycle("st0", 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd11, 32'h55, 32'hDEAD_BEEF);
      for (int k = 1; k <= 2; k++) begin
         peek_dm(32'h0);
         chk($sformatf("st%0d.data", k), 64'(bus_if.WB_rd_data), 64'hDEAD_BEEF);
         chk($sformatf("st%0d.count", k), bus_if.instret, snap);
         cycle($sformatf("st%0d", k), 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd11, 32'h55, 32'h0);
      end
      peek_dm(32'h0);
      chk("st3.data", 64'(bus_if.WB_rd_data), 64'hDEAD_BEEF);
      chk("st3.count", bus_if.instret, snap);
      cycle("st3", 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd11, 32'h55, 32'h0);
      chk("st_done.count", bus_if.instret, snap + 64'd1);

      // Flush with stall on an ALU op, then an ALU write to x0.
      chk("fl.valid_before", 64'(bus_if.WB_valid), 64'd1);
      cycle("fl", 1, 1, 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'h1234, $urandom);
      chk("fl.valid", 64'(bus_if.WB_valid), 64'd0);
      chk("fl.we", 64'(bus_if.WB_reg_write), 64'd0);
      chk("fl.count", bus_if.instret, snap + 64'd1);
      cycle("x0cap", 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'h1234, $urandom);
      chk("x0.valid", 64'(bus_if.WB_valid), 64'd1);
      chk("x0.we", 64'(bus_if.WB_reg_write), 64'd0);
      chk("x0.data", 64'(bus_if.WB_rd_data), 64'h1234);
      cycle("x0", 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd12, $urandom, $urandom);
      chk("x0.count", bus_if.instret, snap + 64'd2);

      // Counter wrap from a preloaded value.
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.r_instret;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      cycle("wrap1", 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd13, $urandom, $urandom);
      chk("wrap1.count", bus_if.instret, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle("wrap2", 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd14, $urandom, $urandom);
      chk("wrap2.count", bus_if.instret, 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         cycle($sformatf("rnd%0d", i),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 31)), $urandom, $urandom);
      end

      // Asynchronous reset mid-cycle with a valid load in WB.
      cycle("pre_rst", 0, 0, 1, 1, 1, 3'b010, 2'd0, 5'd3, $urandom, $urandom);
      bus_if.DM_out = 32'hCAFE_F00D;
      #3;
      rst = 1'b1;
      #1;
      chk("arst.valid", 64'(bus_if.WB_valid), 64'd0);
      chk("arst.we", 64'(bus_if.WB_reg_write), 64'd0);
      chk("arst.rd", 64'(bus_if.WB_rd_addr), 64'd0);
      chk("arst.data", 64'(bus_if.WB_rd_data), 64'd0);
      chk("arst.count", bus_if.instret, 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle("post_rst", 0, 0, 1, 1, 1, 3'b001, 2'd3, 5'd4, $urandom, $urandom);
      peek_dm(32'h9234_ABCD);
      chk("post.data", 64'(bus_if.WB_rd_data), 64'hFFFF_9234);
      chk("post.we", 64'(bus_if.WB_reg_write), 64'd1);
      chk("post.rd", 64'(bus_if.WB_rd_addr), 64'd4);
      cycle("post", 0, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0, $urandom, 32'h9234_ABCD);
      chk("post.count", bus_if.instret, 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
